// File: rtl/reg_file_bypass_pkg.sv
// Shared types and defaults for the bypassing register file.
// Holds the clear-sweep FSM state encoding and default geometry.
package reg_file_bypass_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } rf_state_e;

    localparam int RF_XLEN = 32;
    localparam int RF_NREG = 32;

endpackage

// File: rtl/reg_file_bypass_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// Issue (set) beats long-latency return (clear) on the same address.
module rf_scoreboard
    import reg_file_bypass_pkg::*;
#(
    parameter int NREG    = RF_NREG,
    parameter int AW      = $clog2(NREG),
    parameter int ZERO_R0 = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_all_i,
    input  logic          set_i,
    input  logic [AW-1:0] set_addr_i,
    input  logic          clr_i,
    input  logic [AW-1:0] clr_addr_i,
    input  logic [AW-1:0] rd1_addr_i,
    input  logic [AW-1:0] rd2_addr_i,
    output logic          rd1_busy_o,
    output logic          rd2_busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_all_i) begin
            busy_d = '0;
        end else begin
            if (clr_i) begin
                busy_d[clr_addr_i] = 1'b0;
            end
            if (set_i) begin
                busy_d[set_addr_i] = 1'b1;
            end
        end
        if (ZERO_R0 != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A same-cycle return already bypasses its data, so hide the stale bit.
    always_comb begin
        rd1_busy_o = busy_q[rd1_addr_i] && !(clr_i && (clr_addr_i == rd1_addr_i));
        rd2_busy_o = busy_q[rd2_addr_i] && !(clr_i && (clr_addr_i == rd2_addr_i));
        if ((ZERO_R0 != 0) && (rd1_addr_i == '0)) begin
            rd1_busy_o = 1'b0;
        end
        if ((ZERO_R0 != 0) && (rd2_addr_i == '0)) begin
            rd2_busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_bypass.sv
// Two-write, two-read register file with same-cycle bypass,
// pending-write scoreboard and a sequential zeroing sweep.
module reg_file_bypass
    import reg_file_bypass_pkg::*;
#(
    parameter int XLEN    = RF_XLEN,
    parameter int NREG    = RF_NREG,
    parameter int AW      = $clog2(NREG),
    parameter int ZERO_R0 = 1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            WR0_EN,
    input  logic [AW-1:0]   WR0_ADDR,
    input  logic [XLEN-1:0] WR0_DATA,
    input  logic            WR1_EN,
    input  logic [AW-1:0]   WR1_ADDR,
    input  logic [XLEN-1:0] WR1_DATA,
    input  logic [AW-1:0]   RD1_ADDR,
    input  logic [AW-1:0]   RD2_ADDR,
    output logic [XLEN-1:0] RD1_DATA,
    output logic [XLEN-1:0] RD2_DATA,
    output logic            RD1_BUSY,
    output logic            RD2_BUSY,
    input  logic            SB_SET,
    input  logic [AW-1:0]   SB_ADDR,
    input  logic            CLEAR,
    output logic            READY
);

    localparam logic [AW-1:0] IDX_LAST = AW'(NREG - 1);

    rf_state_e       state_q;
    rf_state_e       state_d;
    logic [AW-1:0]   idx_q;
    logic [AW-1:0]   idx_d;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            ready;
    logic            sweep_start;
    logic            wr0_go;
    logic            wr1_go;
    logic            sb_go;

    assign ready       = (state_q == IDLE);
    assign sweep_start = ready && CLEAR;
    assign wr0_go      = ready && WR0_EN;
    assign wr1_go      = ready && WR1_EN;
    assign sb_go       = ready && SB_SET;
    assign READY       = ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (CLEAR) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Port 1 is applied first so port 0 overwrites it on an address clash.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (!ready) begin
            regs_d[idx_q] = '0;
        end else begin
            if (wr1_go) begin
                regs_d[WR1_ADDR] = WR1_DATA;
            end
            if (wr0_go) begin
                regs_d[WR0_ADDR] = WR0_DATA;
            end
        end
        if (ZERO_R0 != 0) begin
            regs_d[0] = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        RD1_DATA = regs_q[RD1_ADDR];
        if (wr1_go && (WR1_ADDR == RD1_ADDR)) begin
            RD1_DATA = WR1_DATA;
        end
        if (wr0_go && (WR0_ADDR == RD1_ADDR)) begin
            RD1_DATA = WR0_DATA;
        end
        if ((ZERO_R0 != 0) && (RD1_ADDR == '0)) begin
            RD1_DATA = '0;
        end
    end

    always_comb begin
        RD2_DATA = regs_q[RD2_ADDR];
        if (wr1_go && (WR1_ADDR == RD2_ADDR)) begin
            RD2_DATA = WR1_DATA;
        end
        if (wr0_go && (WR0_ADDR == RD2_ADDR)) begin
            RD2_DATA = WR0_DATA;
        end
        if ((ZERO_R0 != 0) && (RD2_ADDR == '0)) begin
            RD2_DATA = '0;
        end
    end

    rf_scoreboard #(
        .NREG    (NREG),
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk_i      (CLK),
        .rst_ni     (RESET_N),
        .clr_all_i  (sweep_start),
        .set_i      (sb_go),
        .set_addr_i (SB_ADDR),
        .clr_i      (wr1_go),
        .clr_addr_i (WR1_ADDR),
        .rd1_addr_i (RD1_ADDR),
        .rd2_addr_i (RD2_ADDR),
        .rd1_busy_o (RD1_BUSY),
        .rd2_busy_o (RD2_BUSY)
    );

endmodule

// File: tb/tb_reg_file_bypass.sv
// Bench for reg_file_bypass: array model checked every cycle
// plus directed scenarios with literal expectations.
module tb_reg_file_bypass;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        WR0_EN, WR1_EN, SB_SET, CLEAR;
    logic [4:0]  WR0_ADDR, WR1_ADDR, RD1_ADDR, RD2_ADDR, SB_ADDR;
    logic [31:0] WR0_DATA, WR1_DATA;
    logic [31:0] RD1_DATA, RD2_DATA;
    logic        RD1_BUSY, RD2_BUSY, READY;

    int errs = 0;
    int checks = 0;

    logic [31:0] mreg [32];
    logic        mbusy [32];
    int          msweep = 0;

    reg_file_bypass dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .WR0_EN(WR0_EN), .WR0_ADDR(WR0_ADDR), .WR0_DATA(WR0_DATA),
        .WR1_EN(WR1_EN), .WR1_ADDR(WR1_ADDR), .WR1_DATA(WR1_DATA),
        .RD1_ADDR(RD1_ADDR), .RD2_ADDR(RD2_ADDR),
        .RD1_DATA(RD1_DATA), .RD2_DATA(RD2_DATA),
        .RD1_BUSY(RD1_BUSY), .RD2_BUSY(RD2_BUSY),
        .SB_SET(SB_SET), .SB_ADDR(SB_ADDR),
        .CLEAR(CLEAR), .READY(READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: plain arrays, a sweep countdown, rules applied at each edge.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 32; i++) begin
                mreg[i] = '0;
                mbusy[i] = 1'b0;
            end
            msweep = 0;
        end else if (msweep > 0) begin
            mreg[5'(32 - msweep)] = '0;
            msweep--;
        end else begin
            if (WR1_EN && WR1_ADDR != 0) begin
                mreg[WR1_ADDR] = WR1_DATA;
                mbusy[WR1_ADDR] = 1'b0;
            end
            if (WR0_EN && WR0_ADDR != 0) mreg[WR0_ADDR] = WR0_DATA;
            if (SB_SET && SB_ADDR != 0) mbusy[SB_ADDR] = 1'b1;
            if (CLEAR) begin
                for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
                msweep = 32;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return '0;
        if (msweep == 0 && WR0_EN && WR0_ADDR == a) return WR0_DATA;
        if (msweep == 0 && WR1_EN && WR1_ADDR == a) return WR1_DATA;
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (msweep == 0 && WR1_EN && WR1_ADDR == a) return 1'b0;
        return mbusy[a];
    endfunction

    always @(negedge CLK) begin
        chk("m_rd1", RD1_DATA, exp_rd(RD1_ADDR));
        chk("m_rd2", RD2_DATA, exp_rd(RD2_ADDR));
        chk("m_busy1", {31'b0, RD1_BUSY}, {31'b0, exp_busy(RD1_ADDR)});
        chk("m_busy2", {31'b0, RD2_BUSY}, {31'b0, exp_busy(RD2_ADDR)});
        chk("m_ready", {31'b0, READY}, {31'b0, msweep == 0});
    end

    task automatic idle();
        WR0_EN = 0; WR1_EN = 0; SB_SET = 0; CLEAR = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    int cnt;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mreg[i] = '0;
            mbusy[i] = 1'b0;
        end
        idle();
        WR0_ADDR = 0; WR1_ADDR = 0; SB_ADDR = 0;
        WR0_DATA = 0; WR1_DATA = 0;
        RD1_ADDR = 5; RD2_ADDR = 7;
        #2;
        chk("rst_rd1", RD1_DATA, 32'h0);
        chk("rst_ready", {31'b0, READY}, 32'h1);
        step(); step();
        RESET_N = 1;

        // write then read back
        step();
        WR0_EN = 1; WR0_ADDR = 5; WR0_DATA = 32'h1234_5678;
        step();
        idle(); RD1_ADDR = 5;
        @(negedge CLK);
        chk("x5_read", RD1_DATA, 32'h1234_5678);

        // dual write same address, port 0 wins
        step();
        WR0_EN = 1; WR0_ADDR = 7; WR0_DATA = 32'hAAAA_0000;
        WR1_EN = 1; WR1_ADDR = 7; WR1_DATA = 32'h5555_0000;
        RD2_ADDR = 7;
        @(negedge CLK);
        chk("x7_bypass", RD2_DATA, 32'hAAAA_0000);
        step();
        idle();
        @(negedge CLK);
        chk("x7_stored", RD2_DATA, 32'hAAAA_0000);

        // register zero
        step();
        WR0_EN = 1; WR0_ADDR = 0; WR0_DATA = 32'hFFFF_FFFF; RD1_ADDR = 0;
        @(negedge CLK);
        chk("x0_bypass", RD1_DATA, 32'h0);
        step();
        WR0_EN = 0; SB_SET = 1; SB_ADDR = 0;
        @(negedge CLK);
        chk("x0_rd", RD1_DATA, 32'h0);
        step();
        idle();
        @(negedge CLK);
        chk("x0_busy", {31'b0, RD1_BUSY}, 32'h0);

        // scoreboard set then long-latency return
        step();
        SB_SET = 1; SB_ADDR = 9;
        step();
        idle(); RD1_ADDR = 9;
        @(negedge CLK);
        chk("x9_busy", {31'b0, RD1_BUSY}, 32'h1);
        step();
        WR1_EN = 1; WR1_ADDR = 9; WR1_DATA = 32'h42;
        @(negedge CLK);
        chk("x9_ret_busy", {31'b0, RD1_BUSY}, 32'h0);
        chk("x9_ret_data", RD1_DATA, 32'h42);
        step();
        idle();
        @(negedge CLK);
        chk("x9_after", RD1_DATA, 32'h42);

        // set and clear same address: set wins
        step();
        SB_SET = 1; SB_ADDR = 10;
        WR1_EN = 1; WR1_ADDR = 10; WR1_DATA = 32'h77;
        RD2_ADDR = 10;
        @(negedge CLK);
        chk("x10_same_busy", {31'b0, RD2_BUSY}, 32'h0);
        chk("x10_same_data", RD2_DATA, 32'h77);
        step();
        idle();
        @(negedge CLK);
        chk("x10_set_wins", {31'b0, RD2_BUSY}, 32'h1);

        // fill and sweep
        for (int i = 1; i < 32; i++) begin
            step();
            idle();
            WR0_EN = 1; WR0_ADDR = 5'(i); WR0_DATA = 32'(i) * 32'h0101_0101;
            if (i == 12) begin
                SB_SET = 1; SB_ADDR = 12;
            end
        end
        step();
        idle(); RD1_ADDR = 31; RD2_ADDR = 12;
        @(negedge CLK);
        chk("x31_fill", RD1_DATA, 32'h1F1F_1F1F);
        chk("x12_busy", {31'b0, RD2_BUSY}, 32'h1);
        step();
        CLEAR = 1; RD1_ADDR = 4; RD2_ADDR = 31;
        step();
        CLEAR = 0;
        WR0_EN = 1; WR0_ADDR = 4; WR0_DATA = 32'hDEAD_BEEF;
        SB_SET = 1; SB_ADDR = 5;
        cnt = 0;
        while (!READY && cnt < 40) begin
            cnt++;
            step();
            CLEAR = (cnt == 3);
        end
        idle();
        chk("sweep_len", 32'(cnt), 32'd32);
        for (int a = 0; a < 32; a++) begin
            RD1_ADDR = 5'(a); RD2_ADDR = 5'(a);
            #1;
            chk("post_clear", RD1_DATA, 32'h0);
            chk("post_busy", {31'b0, RD2_BUSY}, 32'h0);
        end

        // reset during sweep
        step();
        WR0_EN = 1; WR0_ADDR = 20; WR0_DATA = 32'hBEEF_0020;
        step();
        idle(); CLEAR = 1; RD1_ADDR = 20;
        step();
        CLEAR = 0;
        for (int k = 0; k < 9; k++) step();
        @(negedge CLK);
        chk("x20_unswept", RD1_DATA, 32'hBEEF_0020);
        step();
        RESET_N = 0;
        #1;
        chk("arst_ready", {31'b0, READY}, 32'h1);
        chk("arst_x20", RD1_DATA, 32'h0);
        step(); step();
        RESET_N = 1;
        step(); step();
        chk("idle_ready", {31'b0, READY}, 32'h1);
        WR0_EN = 1; WR0_ADDR = 20; WR0_DATA = 32'h5;
        step();
        idle();
        @(negedge CLK);
        chk("post_rst_wr", RD1_DATA, 32'h5);

        step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
